// File: rtl/player_lives_controller.sv
// player_lives_controller: owns the ship's hit / explode / respawn / invulnerability
// sequence and the spare-life count. All sequence timing advances on fsync frame pulses.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | not playing; lives reload while on the start screen
// S_ALIVE  | ship drawn and vulnerable; collisions latch until the next fsync
// S_EXPLODE| ship hidden for RESPAWN_FRAMES frames after a hit
// S_INVULN | ship blinks (8-frame phases) and ignores hits for INVULN_FRAMES
// S_DEAD   | final hit taken; wait for the game to leave PLAY_GAME
module player_lives_controller #(
    parameter int START_LIVES       = 2,
    parameter int RESPAWN_FRAMES    = 60,
    parameter int INVULN_FRAMES     = 120,
    parameter int EXTRA_LIFE_ROUNDS = 4
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       fsync,
    input  logic [1:0] game_state,
    input  logic [4:0] round,
    input  logic       collision,
    output logic       player_hit,
    output logic [1:0] lives_remaining,
    output logic       player_visible,
    output logic       player_invuln,
    output logic       respawn_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIVE,
        S_EXPLODE,
        S_INVULN,
        S_DEAD
    } state_t;

    // Counter must cover the longer duration and expose bit 3 for the blink phase.
    localparam int MAX_FRAMES = (RESPAWN_FRAMES > INVULN_FRAMES) ? RESPAWN_FRAMES : INVULN_FRAMES;
    localparam int CW_RAW     = $clog2(MAX_FRAMES + 1);
    localparam int CW         = (CW_RAW < 4) ? 4 : CW_RAW;

    localparam logic [CW-1:0] RESP_LAST  = CW'(RESPAWN_FRAMES - 1);
    localparam logic [CW-1:0] INV_LAST   = CW'(INVULN_FRAMES - 1);
    localparam logic [1:0]    START_L    = 2'(START_LIVES);
    // Divisor kept nonzero so the modulo stays legal when bonus lives are disabled.
    localparam int            EXTRA_DIV  = (EXTRA_LIFE_ROUNDS == 0) ? 1 : EXTRA_LIFE_ROUNDS;

    state_t        state, state_nxt;
    logic [CW-1:0] frame_cnt, frame_cnt_nxt;
    logic          hit_pend, hit_pend_nxt;
    logic          player_hit_nxt;
    logic          visible_nxt, invuln_nxt, busy_nxt;
    logic [1:0]    lives_nxt;
    logic [4:0]    round_q;
    logic          playing;
    logic          extra_life;
    logic [2:0]    lives_sum;

    assign playing = (game_state == 2'd1);

    // Next state, frame counter, hit latch and qualified hit pulse.
    always_comb begin
        state_nxt      = state;
        frame_cnt_nxt  = frame_cnt;
        hit_pend_nxt   = 1'b0;
        player_hit_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (playing) begin
                    state_nxt     = S_ALIVE;
                    frame_cnt_nxt = '0;
                end
            end
            S_ALIVE: begin
                hit_pend_nxt = hit_pend | collision;
                if (fsync && (hit_pend || collision)) begin
                    player_hit_nxt = 1'b1;
                    hit_pend_nxt   = 1'b0;
                    frame_cnt_nxt  = '0;
                    state_nxt      = (lives_remaining == 2'd0) ? S_DEAD : S_EXPLODE;
                end
            end
            S_EXPLODE: begin
                if (fsync) begin
                    if (frame_cnt == RESP_LAST) begin
                        state_nxt     = S_INVULN;
                        frame_cnt_nxt = '0;
                    end else begin
                        frame_cnt_nxt = frame_cnt + CW'(1);
                    end
                end
            end
            S_INVULN: begin
                if (fsync) begin
                    if (frame_cnt == INV_LAST) begin
                        state_nxt     = S_ALIVE;
                        frame_cnt_nxt = '0;
                    end else begin
                        frame_cnt_nxt = frame_cnt + CW'(1);
                    end
                end
            end
            S_DEAD: begin
                state_nxt = S_DEAD;
            end
            default: begin
                state_nxt     = S_IDLE;
                frame_cnt_nxt = '0;
            end
        endcase

        // Leaving PLAY_GAME abandons whatever sequence is in progress.
        if (state != S_IDLE && !playing) begin
            state_nxt      = S_IDLE;
            frame_cnt_nxt  = '0;
            hit_pend_nxt   = 1'b0;
            player_hit_nxt = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        visible_nxt = 1'b0;
        invuln_nxt  = 1'b0;
        busy_nxt    = 1'b0;
        case (state_nxt)
            S_ALIVE:   visible_nxt = 1'b1;
            S_EXPLODE: busy_nxt    = 1'b1;
            S_INVULN: begin
                invuln_nxt  = 1'b1;
                visible_nxt = ~frame_cnt_nxt[3];
            end
            default: begin
                visible_nxt = 1'b0;
            end
        endcase
    end

    // Life count: reload on start screen, otherwise bonus minus hit, clamped to 0..3.
    always_comb begin
        extra_life = 1'b0;
        if (state != S_IDLE && EXTRA_LIFE_ROUNDS != 0 && round != round_q &&
            round != 5'd0 && (32'(round) % EXTRA_DIV) == 0) begin
            extra_life = 1'b1;
        end
        lives_sum = {1'b0, lives_remaining} + {2'b00, extra_life};
        if (player_hit && lives_sum != 3'd0) begin
            lives_sum = lives_sum - 3'd1;
        end
        lives_nxt = (lives_sum > 3'd3) ? 2'd3 : lives_sum[1:0];
        if (state == S_IDLE && game_state == 2'd0) begin
            lives_nxt = START_L;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state           <= S_IDLE;
            frame_cnt       <= '0;
            hit_pend        <= 1'b0;
            player_hit      <= 1'b0;
            lives_remaining <= START_L;
            player_visible  <= 1'b0;
            player_invuln   <= 1'b0;
            respawn_busy    <= 1'b0;
            round_q         <= '0;
        end else begin
            state           <= state_nxt;
            frame_cnt       <= frame_cnt_nxt;
            hit_pend        <= hit_pend_nxt;
            player_hit      <= player_hit_nxt;
            lives_remaining <= lives_nxt;
            player_visible  <= visible_nxt;
            player_invuln   <= invuln_nxt;
            respawn_busy    <= busy_nxt;
            round_q         <= round;
        end
    end

endmodule

// File: tb/tb_player_lives_controller.sv
// Bench for player_lives_controller: directed scenarios then random traffic,
// every cycle compared against a frame-level behavioural model.
module tb_player_lives_controller;

    localparam int START_LIVES = 2;
    localparam int RESP        = 3;
    localparam int INV         = 20;
    localparam int EXTRA       = 4;

    localparam int M_IDLE    = 0;
    localparam int M_ALIVE   = 1;
    localparam int M_EXPLODE = 2;
    localparam int M_INVULN  = 3;
    localparam int M_DEAD    = 4;

    logic       pixel_clk = 1'b0;
    logic       rst = 1'b1;
    logic       fsync = 1'b0;
    logic [1:0] game_state = 2'd0;
    logic [4:0] round = 5'd0;
    logic       collision = 1'b0;
    logic       player_hit;
    logic [1:0] lives_remaining;
    logic       player_visible;
    logic       player_invuln;
    logic       respawn_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode, frames still to go in the current timed phase, pending hit,
    // life count, expected hit pulse and previous round.
    int m_mode       = M_IDLE;
    int m_left       = 0;
    int m_lives      = START_LIVES;
    int m_prev_round = 0;
    bit m_pend       = 1'b0;
    bit m_hit        = 1'b0;

    always #5 pixel_clk = ~pixel_clk;

    player_lives_controller #(
        .START_LIVES      (START_LIVES),
        .RESPAWN_FRAMES   (RESP),
        .INVULN_FRAMES    (INV),
        .EXTRA_LIFE_ROUNDS(EXTRA)
    ) dut (
        .pixel_clk      (pixel_clk),
        .rst            (rst),
        .fsync          (fsync),
        .game_state     (game_state),
        .round          (round),
        .collision      (collision),
        .player_hit     (player_hit),
        .lives_remaining(lives_remaining),
        .player_visible (player_visible),
        .player_invuln  (player_invuln),
        .respawn_busy   (respawn_busy)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit playing;
        bit extra;
        int sum;
        int old_lives;
        if (rst) begin
            m_mode = M_IDLE; m_left = 0; m_lives = START_LIVES;
            m_prev_round = 0; m_pend = 1'b0; m_hit = 1'b0;
        end else begin
            playing   = (game_state == 2'd1);
            old_lives = m_lives;
            extra = (m_mode != M_IDLE) && (int'(round) != m_prev_round) &&
                    (round != 5'd0) && ((int'(round) % EXTRA) == 0);
            if (m_mode == M_IDLE && game_state == 2'd0) begin
                m_lives = START_LIVES;
            end else begin
                sum = m_lives + (extra ? 1 : 0) - (m_hit ? 1 : 0);
                if (sum < 0) sum = 0;
                if (sum > 3) sum = 3;
                m_lives = sum;
            end
            m_hit = 1'b0;
            if (m_mode != M_IDLE && !playing) begin
                m_mode = M_IDLE; m_pend = 1'b0; m_left = 0;
            end else begin
                case (m_mode)
                    M_IDLE: if (playing) m_mode = M_ALIVE;
                    M_ALIVE: begin
                        if (fsync && (m_pend || collision)) begin
                            m_hit  = 1'b1;
                            m_pend = 1'b0;
                            m_mode = (old_lives == 0) ? M_DEAD : M_EXPLODE;
                            m_left = RESP;
                        end else begin
                            m_pend = m_pend | collision;
                        end
                    end
                    M_EXPLODE: begin
                        m_pend = 1'b0;
                        if (fsync) begin
                            m_left--;
                            if (m_left == 0) begin m_mode = M_INVULN; m_left = INV; end
                        end
                    end
                    M_INVULN: begin
                        m_pend = 1'b0;
                        if (fsync) begin
                            m_left--;
                            if (m_left == 0) m_mode = M_ALIVE;
                        end
                    end
                    default: m_pend = 1'b0;
                endcase
            end
            m_prev_round = int'(round);
        end
    endtask

    task automatic check_all();
        bit exp_vis;
        exp_vis = 1'b0;
        if (m_mode == M_ALIVE) exp_vis = 1'b1;
        if (m_mode == M_INVULN) exp_vis = (((INV - m_left) / 8) % 2) == 0;
        check("model_player_hit", 8'(player_hit), 8'(m_hit));
        check("model_lives", 8'(lives_remaining), 8'(m_lives));
        check("model_visible", 8'(player_visible), 8'(exp_vis));
        check("model_invuln", 8'(player_invuln), 8'(m_mode == M_INVULN));
        check("model_busy", 8'(respawn_busy), 8'(m_mode == M_EXPLODE));
    endtask

    task automatic step();
        @(posedge pixel_clk);
        model_step();
        #1;
        check_all();
        rst       = 1'b0;
        fsync     = 1'b0;
        collision = 1'b0;
    endtask

    task automatic frame(input int n);
        repeat (n) begin
            fsync = 1'b1;
            step();
            step();
            step();
        end
    endtask

    task automatic do_hit();
        collision = 1'b1;
        step();
        step();
        fsync = 1'b1;
        step();
    endtask

    initial begin
        int hits;

        // Reset and start
        round = 5'd3; game_state = 2'd0; rst = 1'b1;
        step();
        check("reset_lives", 8'(lives_remaining), 8'd2);
        check("reset_hit", 8'(player_hit), 8'd0);
        check("reset_visible", 8'(player_visible), 8'd0);
        check("reset_busy", 8'(respawn_busy), 8'd0);
        step(); step();
        game_state = 2'd1;
        step();
        check("start_visible", 8'(player_visible), 8'd1);
        check("start_lives", 8'(lives_remaining), 8'd2);
        step(); step();

        // First hit
        do_hit();
        check("hit1_pulse", 8'(player_hit), 8'd1);
        check("hit1_lives_pre", 8'(lives_remaining), 8'd2);
        check("hit1_busy", 8'(respawn_busy), 8'd1);
        step();
        check("hit1_pulse_end", 8'(player_hit), 8'd0);
        check("hit1_lives_post", 8'(lives_remaining), 8'd1);

        // Respawn and blink timing
        frame(2);
        check("explode_busy", 8'(respawn_busy), 8'd1);
        frame(1);
        check("invuln_entry", 8'(player_invuln), 8'd1);
        check("invuln_f0_visible", 8'(player_visible), 8'd1);
        frame(8);
        check("invuln_f8_visible", 8'(player_visible), 8'd0);
        collision = 1'b1;
        step();
        fsync = 1'b1;
        step();
        check("invuln_no_hit", 8'(player_hit), 8'd0);
        step(); step();
        frame(7);
        check("invuln_f16_visible", 8'(player_visible), 8'd1);
        frame(3);
        check("invuln_f19", 8'(player_invuln), 8'd1);
        frame(1);
        check("back_alive_invuln", 8'(player_invuln), 8'd0);
        check("back_alive_visible", 8'(player_visible), 8'd1);

        // Extra lives
        round = 5'd4;
        step();
        check("extra_life_4", 8'(lives_remaining), 8'd2);
        for (int r = 5; r <= 8; r++) begin round = 5'(r); step(); step(); end
        check("extra_life_8", 8'(lives_remaining), 8'd3);
        for (int r = 9; r <= 12; r++) begin round = 5'(r); step(); step(); end
        check("extra_saturate", 8'(lives_remaining), 8'd3);

        do_hit(); step();
        check("hit2_lives", 8'(lives_remaining), 8'd2);
        frame(RESP); frame(INV);

        // Bonus on the decrement cycle cancels out
        do_hit();
        check("hit3_pulse", 8'(player_hit), 8'd1);
        round = 5'd16;
        step();
        check("coincident_lives", 8'(lives_remaining), 8'd2);
        frame(RESP); frame(INV);

        do_hit(); step(); frame(RESP); frame(INV);
        do_hit(); step();
        check("hit5_lives", 8'(lives_remaining), 8'd0);
        frame(RESP); frame(INV);

        // Final hit
        do_hit();
        check("final_hit_pulse", 8'(player_hit), 8'd1);
        check("final_hit_lives", 8'(lives_remaining), 8'd0);
        step();
        check("dead_visible", 8'(player_visible), 8'd0);
        check("dead_busy", 8'(respawn_busy), 8'd0);
        check("dead_lives", 8'(lives_remaining), 8'd0);
        collision = 1'b1;
        step();
        fsync = 1'b1;
        step();
        check("dead_no_hit", 8'(player_hit), 8'd0);
        game_state = 2'd2;
        step(); step();
        game_state = 2'd0;
        step();
        check("reload_lives", 8'(lives_remaining), 8'd2);

        // Abort during EXPLODE
        game_state = 2'd1;
        step();
        do_hit(); step(); step();
        check("abort_pre_busy", 8'(respawn_busy), 8'd1);
        game_state = 2'd0;
        step();
        check("abort_busy", 8'(respawn_busy), 8'd0);
        check("abort_visible", 8'(player_visible), 8'd0);
        check("abort_invuln", 8'(player_invuln), 8'd0);
        check("abort_hit", 8'(player_hit), 8'd0);

        // Three collisions in one frame collapse to one hit
        step();
        game_state = 2'd1;
        step();
        repeat (3) begin collision = 1'b1; step(); step(); end
        fsync = 1'b1;
        step();
        hits = int'(player_hit);
        repeat (12) begin
            step();
            hits += int'(player_hit);
        end
        check("single_hit", 8'(hits), 8'd1);

        // Reset in the middle of EXPLODE, with a collision on the same cycle
        check("pre_reset_busy", 8'(respawn_busy), 8'd1);
        rst = 1'b1; collision = 1'b1;
        step();
        check("rst_lives", 8'(lives_remaining), 8'd2);
        check("rst_busy", 8'(respawn_busy), 8'd0);
        check("rst_visible", 8'(player_visible), 8'd0);
        check("rst_hit", 8'(player_hit), 8'd0);

        // Random traffic
        game_state = 2'd1;
        step();
        for (int i = 0; i < 4000; i++) begin
            fsync     = ($urandom_range(3) == 0);
            collision = ($urandom_range(5) == 0);
            if ($urandom_range(149) == 0)
                game_state = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'd1;
            if ($urandom_range(19) == 0)
                round = 5'($urandom_range(31));
            rst = ($urandom_range(999) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/player_lives_controller.md
# player_lives_controller

Produces the `player_hit` pulse and `lives_remaining` count consumed by `game_state_machine`, and owns the player's death/respawn/invulnerability sequence. Sits between the collision detector and the game state machine, and feeds sprite visibility to the renderer. All timing advances on `fsync` frame pulses, so respawn and invulnerability durations are measured in frames.

## Interface
- `START_LIVES`, 2: spare lives loaded at start screen (0..3).
- `RESPAWN_FRAMES`, 60: frames the ship is hidden after a hit.
- `INVULN_FRAMES`, 120: frames of post-respawn invulnerability.
- `EXTRA_LIFE_ROUNDS`, 4: bonus life on each round that is a nonzero multiple of this; 0 disables.
- `pixel_clk` in 1: the only clock.
- `rst` in 1: reset, synchronous and active-high.
- `fsync` in 1: one-cycle frame pulse.
- `game_state` in 2: 0 START_SCREEN, 1 PLAY_GAME, 2 GAME_OVER, 3 treated as not-playing.
- `round` in 5: current round from the game state machine.
- `collision` in 1: one-cycle ship-hit pulse from the collision detector, any cycle.
- `player_hit` out 1: one-cycle qualified hit pulse.
- `lives_remaining` out 2: spare lives; 0 means the next hit ends the game.
- `player_visible` out 1: renderer draws the ship.
- `player_invuln` out 1: ship is immune to collisions.
- `respawn_busy` out 1: high in EXPLODE.

## Operation
- States are IDLE, ALIVE, EXPLODE, INVULN and DEAD. `frame_cnt` counts `fsync` pulses in EXPLODE and INVULN.
- **IDLE:** `lives_remaining` reloads to START_LIVES on every cycle that `game_state`==0. Moves to ALIVE on the first cycle `game_state`==1.
- **Hit latch:** `collision` sets a sticky `hit_pend` flag in ALIVE only. In any other state the pulse is discarded and the flag cleared.
- **ALIVE:** on the `fsync` cycle with `hit_pend` set (or `collision` high that same cycle), assert `player_hit` next cycle and clear `hit_pend`.
  - If `lives_remaining`==0, go to DEAD.
  - Otherwise go to EXPLODE, `frame_cnt`=0.
- **EXPLODE:** `player_visible`=0, `respawn_busy`=1. After RESPAWN_FRAMES `fsync` pulses, go to INVULN with `frame_cnt`=0.
- **INVULN:** `player_invuln`=1. `player_visible`=~`frame_cnt`[3], so the ship blinks with 8-frame phases, visible first. After INVULN_FRAMES `fsync` pulses, go to ALIVE.
- **DEAD:** `player_visible`=0. Hold until `game_state`!=1.
- **Abort:** from any non-IDLE state, `game_state`!=1 returns to IDLE next cycle. Counters and `hit_pend` clear.
- **Decrement:** `lives_remaining` decrements by 1 on the cycle after `player_hit`. While `player_hit` is high it still shows the pre-hit value, so the game state machine sees 0 on the final hit. No decrement below 0.
- **Extra life:**
  - The previous round is registered. In any state other than IDLE, a change of `round` to a value with `round`!=0 and `round` % EXTRA_LIFE_ROUNDS==0 adds 1, saturating at 3.
  - If a decrement and an extra life land on the same cycle, the net change is 0 (saturation is applied after the sum).
- **Output values per state:** ALIVE has `player_visible`=1. IDLE has all outputs other than `lives_remaining` at 0.

## Timing
- Reset values: state IDLE; `player_hit`=0; `lives_remaining`=START_LIVES; `player_visible`=0; `player_invuln`=0; `respawn_busy`=0; `hit_pend`=0; `frame_cnt`=0.
- All outputs are registered.
- Latency:
  - `fsync` to `player_hit`: 1 cycle.
  - `player_hit` to `lives_remaining` decrement: 1 cycle.
  - `player_hit` is a single-cycle pulse.
- A `collision` arriving between two `fsync`s is reported at the next `fsync`. Multiple collisions in one frame yield one hit.
- A state change takes effect in the cycle after the `fsync` that completes the count. `frame_cnt` is wide enough for max(RESPAWN_FRAMES, INVULN_FRAMES).
- `rst` mid-sequence overrides everything next edge. `collision` in the same cycle as `rst` is dropped.

## Test plan
- **Start and first hit:** reset, then `game_state`=0 → 1 → `lives_remaining`=2, ALIVE, `player_visible`=1. `collision` then `fsync` → `player_hit` 1 cycle after `fsync`, `lives_remaining`=1 the following cycle, `respawn_busy`=1.
- **Respawn timing:** RESPAWN_FRAMES=3, INVULN_FRAMES=20. After a hit, 3 `fsync`s → INVULN with `player_invuln`=1. `player_visible` reads 1 for frames 0-7, 0 for frames 8-15, 1 for frames 16-19. `collision` during INVULN → no `player_hit`. 20th `fsync` → ALIVE.
- **Final hit:** `lives_remaining`=0 and hit → `player_hit` with `lives_remaining` still 0, then DEAD. `game_state`=2 → IDLE. `game_state`=0 → `lives_remaining`=2.
- **Extra life:** `round` 3→4 → lives +1. At 3, `round` 7→8 → stays 3. `round` change coincident with decrement (lives 2) → stays 2.
- **Abort and collapse:** `game_state`→0 during EXPLODE → IDLE next cycle, all flags 0. Three `collision` pulses in one frame → exactly one `player_hit`.
- **Reset mid-operation:** `rst` asserted during EXPLODE → every output at its reset value next edge.
